// File: rtl/dma_image_stream_reader.sv
// dma_image_stream_reader: DMA read engine streaming a CH x H x W image through a credit-limited response FIFO; DMA_IMG_INTERLEAVE_EN adds pixel-interleaved order
module dma_image_stream_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int IMG_H = 32,
  parameter int IMG_W = 32,
  parameter int NUM_CH = 3,
  parameter int FIFO_DEPTH = 8,
  localparam int TOTAL = IMG_H * IMG_W * NUM_CH,
  localparam int CNT_W = $clog2(TOTAL + 1),
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] plane_stride,
`ifdef DMA_IMG_INTERLEAVE_EN
  input  logic              interleave,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_ch,
  output logic              m_last
);
  localparam int PIX = IMG_H * IMG_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] PLAST = CNT_W'(PIX - 1);
  localparam logic [CH_W-1:0] CLAST = CH_W'(NUM_CH - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] base_q, stride_q, plane_q;
  logic il;
  logic [CNT_W-1:0] req_cnt, req_p, out_cnt, out_p;
  logic [CH_W-1:0] req_c, out_c;
  logic [OW-1:0] outst, fcount;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic accept, fire, push, pop, last_pop;
  // outstanding + buffered never exceeds the FIFO, so a response always has a slot
  assign mem_req_valid = (state == FETCH) & (({1'b0, outst} + {1'b0, fcount}) < (OW+1)'(FIFO_DEPTH));
  assign accept = (state == IDLE) & start;
  assign fire = mem_req_valid & mem_req_ready;
  assign push = mem_resp_valid & (outst != '0);
  assign m_valid = fcount != '0;
  assign pop = m_valid & m_ready;
  assign last_pop = pop & (out_cnt == LAST);
  assign m_data = m_valid ? mem[rd_ptr] : '0;
  assign m_ch = out_c;
  assign m_last = m_valid & (out_cnt == LAST);
  assign mem_req_addr = plane_q + ADDR_W'(req_p);
  assign busy = (state == FETCH) | (state == DRAIN);
  assign done = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? FETCH : IDLE;
      FETCH:   state_nxt = (fire && req_cnt == LAST) ? DRAIN : FETCH;
      DRAIN:   state_nxt = last_pop ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // plane_q holds base + c*stride, advanced by one stride per channel step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base_q <= '0;
      stride_q <= '0;
      plane_q <= '0;
      il <= 1'b0;
      req_cnt <= '0;
      req_p <= '0;
      req_c <= '0;
    end else if (accept) begin
      base_q <= base_addr;
      stride_q <= plane_stride;
      plane_q <= base_addr;
`ifdef DMA_IMG_INTERLEAVE_EN
      il <= interleave;
`else
      il <= 1'b0;
`endif
      req_cnt <= '0;
      req_p <= '0;
      req_c <= '0;
    end else if (fire) begin
      req_cnt <= req_cnt + CNT_W'(1);
      if (il) begin
        req_c <= req_c == CLAST ? '0 : req_c + CH_W'(1);
        plane_q <= req_c == CLAST ? base_q : plane_q + stride_q;
        if (req_c == CLAST) req_p <= req_p + CNT_W'(1);
      end else begin
        req_p <= req_p == PLAST ? '0 : req_p + CNT_W'(1);
        if (req_p == PLAST) begin
          req_c <= req_c == CLAST ? '0 : req_c + CH_W'(1);
          plane_q <= plane_q + stride_q;
        end
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) outst <= '0;
    else outst <= outst + OW'(fire) - OW'(push);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fcount <= fcount + OW'(push) - OW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= mem_resp_rdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_cnt <= '0;
      out_p <= '0;
      out_c <= '0;
    end else if (accept) begin
      out_cnt <= '0;
      out_p <= '0;
      out_c <= '0;
    end else if (pop) begin
      out_cnt <= out_cnt + CNT_W'(1);
      if (il) out_c <= out_c == CLAST ? '0 : out_c + CH_W'(1);
      else begin
        out_p <= out_p == PLAST ? '0 : out_p + CNT_W'(1);
        if (out_p == PLAST) out_c <= out_c == CLAST ? '0 : out_c + CH_W'(1);
      end
    end
endmodule

// File: tb/tb_dma_image_stream_reader.sv
// tb_dma_image_stream_reader: scoreboard bench; expected request addresses and output beats are queued per frame
`timescale 1ns/1ps
module tb_dma_image_stream_reader;
  localparam int DATA_W = 8, ADDR_W = 32, IMG_H = 32, IMG_W = 32, NUM_CH = 3, FIFO_DEPTH = 8;
  localparam int TOTAL = IMG_H * IMG_W * NUM_CH, PIX = IMG_H * IMG_W;
  typedef struct packed {logic [7:0] d; logic [1:0] ch; logic last;} beat_t;
  logic clk = 0, rst = 0, start = 0;
`ifdef DMA_IMG_INTERLEAVE_EN
  logic interleave = 0;
`endif
  logic [ADDR_W-1:0] base_addr = '0, plane_stride = '0, mem_req_addr;
  logic busy, done, mem_req_valid, m_valid, m_last;
  logic mem_req_ready = 0, mem_resp_valid = 0, m_ready = 0;
  logic [DATA_W-1:0] mem_resp_rdata = '0, m_data;
  logic [1:0] m_ch;
  int checks = 0, errors = 0;
  int req_pct = 100, rdy_pct = 100;
  int fired = 0, popped = 0, done_cnt = 0;
  bit frame_done = 0, exp_done = 0;
  logic [ADDR_W-1:0] exp_addr[$], pend[$];
  beat_t exp_beat[$];

  dma_image_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_H(IMG_H), .IMG_W(IMG_W),
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .plane_stride(plane_stride),
`ifdef DMA_IMG_INTERLEAVE_EN
    .interleave(interleave),
`endif
    .busy(busy), .done(done), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .m_last(m_last));

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] ddr(input logic [ADDR_W-1:0] a);
    return a[7:0];
  endfunction

  // memory model + scoreboard: observe at negedge, drive next cycle's inputs just after posedge
  initial begin : agent
    logic [ADDR_W-1:0] a;
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        fired = 0;
        popped = 0;
        exp_done = 0;
      end else begin
        if (fired - popped > FIFO_DEPTH || (mem_req_valid && fired - popped >= FIFO_DEPTH)) begin
          checks++; errors++;
          $display("FAIL credit: outstanding+count=%0d req_valid=%0b limit %0d", fired - popped, mem_req_valid, FIFO_DEPTH);
        end
        if (exp_done) begin
          checks++;
          if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%0b busy=%0b, required done=1 busy=0", done, busy);
          end
          exp_done = 0;
        end else if (done) begin
          checks++; errors++;
          $display("FAIL stray_done: done=1 without preceding last beat");
        end
        if (done) begin
          done_cnt++;
          frame_done = 1;
        end
        if (mem_req_valid && mem_req_ready) begin
          checks++;
          if (exp_addr.size() == 0) begin
            errors++;
            $display("FAIL req_extra: unexpected request addr=%h", mem_req_addr);
          end else begin
            a = exp_addr.pop_front();
            if (mem_req_addr !== a) begin
              errors++;
              $display("FAIL req_addr #%0d: got %h, required %h", fired, mem_req_addr, a);
            end
          end
          pend.push_back(mem_req_addr);
          fired++;
        end
        if (m_valid && m_ready) begin
          checks++;
          if (exp_beat.size() == 0) begin
            errors++;
            $display("FAIL beat_extra: unexpected beat data=%h", m_data);
          end else begin
            b = exp_beat.pop_front();
            if ({m_data, m_ch, m_last} !== b) begin
              errors++;
              $display("FAIL beat #%0d: got data=%h ch=%0d last=%0b, required data=%h ch=%0d last=%0b",
                popped, m_data, m_ch, m_last, b.d, b.ch, b.last);
            end
          end
          popped++;
          if (m_last) exp_done = 1;
        end
      end
      @(posedge clk);
      #1;
      mem_req_ready = int'($urandom_range(99)) < req_pct;
      m_ready = int'($urandom_range(99)) < rdy_pct;
      if (pend.size() > 0 && int'($urandom_range(99)) < req_pct) begin
        mem_resp_valid = 1;
        mem_resp_rdata = ddr(pend.pop_front());
      end else begin
        mem_resp_valid = 0;
        mem_resp_rdata = '0;
      end
    end
  end

  task automatic start_frame(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s, input bit il);
    int c, p;
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < TOTAL; k++) begin
      c = il ? k % NUM_CH : k / PIX;
      p = il ? k / NUM_CH : k % PIX;
      a = b + ADDR_W'(c) * s + ADDR_W'(p);
      exp_addr.push_back(a);
      exp_beat.push_back({ddr(a), 2'(c), k == TOTAL - 1});
    end
    base_addr = b;
    plane_stride = s;
`ifdef DMA_IMG_INTERLEAVE_EN
    interleave = il;
`endif
    frame_done = 0;
    done_cnt = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!frame_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles, got beats=%0d", budget, popped);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1;
    #2;
    checks++;
    if ({busy, done, mem_req_valid, mem_req_addr, m_valid, m_data, m_ch, m_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b req=%0b addr=%h valid=%0b data=%h ch=%0d last=%0b, required all 0",
        busy, done, mem_req_valid, mem_req_addr, m_valid, m_data, m_ch, m_last);
    end
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_planar;
    int cyc;
    req_pct = 100; rdy_pct = 100;
    start_frame(0, 1024, 0);
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_req: req_valid=%0b busy=%0b one cycle after start, required 1 1", mem_req_valid, busy);
    end
    wait_done(TOTAL + 40, cyc);
    checks++;
    if (cyc > TOTAL + 8) begin
      errors++;
      $display("FAIL throughput: frame took %0d cycles, required <= %0d", cyc, TOTAL + 8);
    end
    checks++;
    if (exp_beat.size() != 0 || exp_addr.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL planar_end: left beats=%0d addrs=%0d dones=%0d busy=%0b, required 0 0 1 0",
        exp_beat.size(), exp_addr.size(), done_cnt, busy);
    end
  endtask

  task automatic test_random;
    int cyc;
    req_pct = 70; rdy_pct = 50;
    start_frame(0, 1024, 0);
    wait_done(30000, cyc);
    checks++;
    if (exp_beat.size() != 0 || exp_addr.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL random_end: left beats=%0d addrs=%0d dones=%0d, required 0 0 1", exp_beat.size(), exp_addr.size(), done_cnt);
    end
  endtask

  task automatic test_stride;
    int cyc;
    req_pct = 100; rdy_pct = 100;
    start_frame(32'h100, 2048, 0);
    wait_done(TOTAL + 40, cyc);
    checks++;
    if (exp_beat.size() != 0 || exp_addr.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL stride_end: left beats=%0d addrs=%0d dones=%0d, required 0 0 1", exp_beat.size(), exp_addr.size(), done_cnt);
    end
  endtask

`ifdef DMA_IMG_INTERLEAVE_EN
  task automatic test_interleave;
    int cyc;
    req_pct = 80; rdy_pct = 80;
    start_frame(0, 1024, 1);
    wait_done(20000, cyc);
    checks++;
    if (exp_beat.size() != 0 || exp_addr.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL interleave_end: left beats=%0d addrs=%0d dones=%0d, required 0 0 1", exp_beat.size(), exp_addr.size(), done_cnt);
    end
  endtask
`endif

  task automatic test_double_start;
    int cyc, n;
    req_pct = 100; rdy_pct = 100;
    start_frame(0, 1024, 0);
    n = 0;
    while (popped < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    base_addr = 32'h4000;
    plane_stride = 7;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(TOTAL + 40, cyc);
    repeat (5) @(negedge clk);
    checks++;
    if (exp_beat.size() != 0 || exp_addr.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL double_start: left beats=%0d addrs=%0d dones=%0d busy=%0b, required 0 0 1 0",
        exp_beat.size(), exp_addr.size(), done_cnt, busy);
    end
  endtask

  task automatic test_mid_reset;
    int cyc, n;
    bit bad;
    req_pct = 70; rdy_pct = 30;
    start_frame(0, 1024, 0);
    n = 0;
    while (popped < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    rst = 1;
    #1;
    checks++;
    if ({busy, done, mem_req_valid, mem_req_addr, m_valid, m_data, m_ch, m_last} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%0b done=%0b req=%0b addr=%h valid=%0b data=%h ch=%0d last=%0b, required all 0",
        busy, done, mem_req_valid, mem_req_addr, m_valid, m_data, m_ch, m_last);
    end
    exp_addr.delete();
    exp_beat.delete();
    done_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    bad = 0;
    n = 0;
    while ((pend.size() > 0 || n < 4) && n < 200) begin
      @(negedge clk);
      if (m_valid || busy || done) bad = 1;
      n++;
    end
    checks++;
    if (bad || pend.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL late_resp: m_valid/busy/done seen=%0b pending=%0d dones=%0d, required 0 0 0", bad, pend.size(), done_cnt);
    end
    start_frame(0, 1024, 0);
    wait_done(30000, cyc);
    checks++;
    if (exp_beat.size() != 0 || exp_addr.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL after_reset_frame: left beats=%0d addrs=%0d dones=%0d, required 0 0 1", exp_beat.size(), exp_addr.size(), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_planar();
    test_random();
    test_stride();
`ifdef DMA_IMG_INTERLEAVE_EN
    test_interleave();
`endif
    test_double_start();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
